chunked_serial_adder: RTL and testbench

//   Multi-cycle WIDTH-bit adder. Each cycle it adds CHUNK bits through a ripple slice of

---
 rtl/adder_pkg.sv | 26 ++
 rtl/adder_slice.sv | 29 ++
 rtl/chunked_serial_adder.sv | 152 +++++++++++++++
 tb/tb_chunked_serial_adder.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/adder_pkg.sv
// Shared constants for the chunked serial adder: FSM encoding and chunk/count sizing helpers.
package adder_pkg;

  // FSM state encoding
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Default geometry
  localparam int unsigned DEF_WIDTH = 16;
  localparam int unsigned DEF_CHUNK = 4;

  // Number of chunk cycles for one operation
  function automatic int unsigned nchunk(input int unsigned width, input int unsigned chunk);
    return width / chunk;
  endfunction

  // Chunk counter width; at least one bit even when a single chunk covers the operand
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int unsigned DEF_NCHUNK = nchunk(DEF_WIDTH, DEF_CHUNK);
  localparam int unsigned DEF_CNT_W  = cnt_width(DEF_NCHUNK);

endpackage

// File: rtl/adder_slice.sv
// Combinational CHUNK-bit ripple of full adders; also exposes the carry into the slice MSB.
module adder_slice #(
  parameter int unsigned CHUNK = 4
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             ci,
  output logic [CHUNK-1:0] s,
  output logic             co,
  output logic             c_msb_in
);

  logic [CHUNK:0] c;

  // Ripple the carry bit by bit through the slice
  always_comb begin
    c    = '0;
    s    = '0;
    c[0] = ci;
    for (int i = 0; i < int'(CHUNK); i++) begin
      s[i]   = a[i] ^ b[i] ^ c[i];
      c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
  end

  assign co       = c[CHUNK];
  assign c_msb_in = c[CHUNK-1];

endmodule

// File: rtl/chunked_serial_adder.sv
// Multi-cycle WIDTH-bit adder processing CHUNK bits per cycle with valid/ready handshakes.
// Optional feature: define SUBTRACTOR_EN to add the 'sub' port (a-b via ~b and forced carry-in).
module chunked_serial_adder
  import adder_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned CHUNK = DEF_CHUNK
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef SUBTRACTOR_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int unsigned NCHUNK = nchunk(WIDTH, CHUNK);
  localparam int unsigned CNT_W  = cnt_width(NCHUNK);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NCHUNK - 1);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;

  logic [31:0]      base;
  logic [CHUNK-1:0] slice_a, slice_b, slice_s;
  logic             slice_co, slice_cmsb;
  logic             sub_sel;

`ifdef SUBTRACTOR_EN
  assign sub_sel = sub;
`else
  assign sub_sel = 1'b0;
`endif

  // Select the current chunk of each operand
  assign base    = 32'(cnt_q) * 32'(CHUNK);
  assign slice_a = a_q[base +: CHUNK];
  assign slice_b = b_q[base +: CHUNK];

  adder_slice #(
    .CHUNK(CHUNK)
  ) u_slice (
    .a       (slice_a),
    .b       (slice_b),
    .ci      (carry_q),
    .s       (slice_s),
    .co      (slice_co),
    .c_msb_in(slice_cmsb)
  );

  // Next-state, datapath and handshake decode
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    a_d         = a_q;
    b_d         = b_q;
    carry_d     = carry_q;
    sum_d       = sum_q;
    cout_d      = cout_q;
    ovf_d       = ovf_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;

    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = sub_sel ? ~b : b;
          carry_d = sub_sel ? 1'b1 : cin;
          cnt_d   = '0;
          sum_d   = '0;
          cout_d  = 1'b0;
          ovf_d   = 1'b0;
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        sum_d[base +: CHUNK] = slice_s;
        carry_d              = slice_co;
        cnt_d                = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          cout_d  = slice_co;
          ovf_d   = slice_co ^ slice_cmsb;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    in_ready_d  = (state_d == ST_IDLE);
    out_valid_d = (state_d == ST_DONE);
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      carry_q     <= 1'b0;
      sum_q       <= '0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      a_q         <= a_d;
      b_q         <= b_d;
      carry_q     <= carry_d;
      sum_q       <= sum_d;
      cout_q      <= cout_d;
      ovf_q       <= ovf_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_chunked_serial_adder.sv
// Randomized self-checking bench for chunked_serial_adder (WIDTH=16, CHUNK=4).
module tb_chunked_serial_adder;

  localparam int unsigned WIDTH  = 16;
  localparam int unsigned CHUNK  = 4;
  localparam int unsigned NCHUNK = WIDTH / CHUNK;
`ifdef SUBTRACTOR_EN
  localparam bit SUB_ON = 1'b1;
`else
  localparam bit SUB_ON = 1'b0;
`endif

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  int n_checks = 0;
  int n_errors = 0;

  chunked_serial_adder #(
    .WIDTH(WIDTH),
    .CHUNK(CHUNK)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .cin      (cin),
`ifdef SUBTRACTOR_EN
    .sub      (sub),
`endif
    .out_valid(out_valid),
    .out_ready(out_ready),
    .sum      (sum),
    .cout     (cout),
    .ovf      (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: whole-word arithmetic, returns {ovf, cout, sum}
  function automatic logic [17:0] model(input logic [15:0] av, input logic [15:0] bv,
                                        input logic ci, input logic sb);
    logic [15:0] bb;
    logic        c;
    logic [16:0] r;
    logic        v;
    bb = (SUB_ON && sb) ? ~bv : bv;
    c  = (SUB_ON && sb) ? 1'b1 : ci;
    r  = {1'b0, av} + {1'b0, bb} + 17'(c);
    v  = (av[15] == bb[15]) && (r[15] != av[15]);
    return {v, r[16], r[15:0]};
  endfunction

  // Issue one operation, check latency and result, optionally stall in DONE for 'hold' cycles
  task automatic run_op(input logic [15:0] av, input logic [15:0] bv, input logic ci,
                        input logic sb, input int hold);
    logic [17:0] exp;
    int          cyc;
    exp = model(av, bv, ci, sb);
    a = av; b = bv; cin = ci; sub = sb; in_valid = 1'b1;
    out_ready = (hold == 0);
    cyc = 0;
    while (!in_ready && cyc < 50) begin
      @(posedge clk); #1; cyc++;
    end
    if (!in_ready) begin
      check("accept_timeout", 32'(in_ready), 32'd1);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = 16'($urandom); b = 16'($urandom);
    cyc = 0;
    while (!out_valid && cyc < 50) begin
      @(posedge clk); #1; cyc++;
    end
    if (!out_valid) begin
      check("result_timeout", 32'(out_valid), 32'd1);
      return;
    end
    check("latency", 32'(cyc), 32'(NCHUNK));
    check("sum", 32'(sum), 32'(exp[15:0]));
    check("cout", 32'(cout), 32'(exp[16]));
    check("ovf", 32'(ovf), 32'(exp[17]));
    check("in_ready_done", 32'(in_ready), 32'd0);
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1;
      @(posedge clk); #1;
      check("hold_valid", 32'(out_valid), 32'd1);
      check("hold_sum", 32'(sum), 32'(exp[15:0]));
      check("hold_cout", 32'(cout), 32'(exp[16]));
      check("hold_in_ready", 32'(in_ready), 32'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("post_out_valid", 32'(out_valid), 32'd0);
    check("post_in_ready", 32'(in_ready), 32'd1);
    check("post_sum_hold", 32'(sum), 32'(exp[15:0]));
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_sum", 32'(sum), 32'd0);
    check("rst_cout", 32'(cout), 32'd0);
    check("rst_ovf", 32'(ovf), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed arithmetic corners
    run_op(16'h1234, 16'h4321, 1'b0, 1'b0, 0);
    run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 0);
    run_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, 0);
    run_op(16'h0000, 16'h0000, 1'b1, 1'b0, 0);
    run_op(16'h8000, 16'h8000, 1'b1, 1'b0, 0);

    // Backpressure with in_valid held in DONE, then the pending operands go in
    run_op(16'hABCD, 16'h1111, 1'b0, 1'b0, 5);
    run_op(16'h0F0F, 16'hF0F1, 1'b0, 1'b0, 0);

    // Reset during the second BUSY cycle abandons the operation
    a = 16'h1234; b = 16'h4321; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_sum", 32'(sum), 32'd0);
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_op(16'h1234, 16'h4321, 1'b0, 1'b0, 0);

    if (SUB_ON) begin
      run_op(16'h0005, 16'h0007, 1'b0, 1'b1, 0);
      run_op(16'h8000, 16'h0001, 1'b0, 1'b1, 0);
    end

    // Randomized operations with random backpressure
    for (int n = 0; n < 150; n++) begin
      run_op(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom),
             int'($urandom_range(0, 3)));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
